apu_mixer: RTL and testbench

The APU mixer sits directly downstream of the per-channel sample generators. On every `sample_tick` it polls each channel in turn and scales the channel's current 16-bit sample by its 8-bit volume. It routes the scaled sample to the left bus, the right bus or both, then accumulates the results. The two sums are saturated to signed 16 bits and presented to the audio output stage with a one-cycle `out_valid` strobe.

---
 rtl/apu_mixer.sv | 159 +++++++++++++++
 tb/tb_apu_mixer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apu_mixer.sv
// rtl/apu_mixer.sv - per-frame multi-channel volume mixer with left/right routing and output saturation
//
// Purpose:
//   On each sample_tick, polls every channel in turn through a req/valid handshake.
//   Each channel sample is multiplied by its volume and added to the left bus, the
//   right bus, or both. Each bus sum is then scaled down by the volume width,
//   saturated to SAMPLE_W bits, and presented with a one-cycle out_valid strobe.
//
// Ports:
//   clk, rst                          clock, asynchronous active-low reset
//   sample_tick                       frame start pulse
//   ch_req, ch_sel                    channel poll request and index
//   ch_valid, ch_sample, ch_volume,
//   ch_playing, ch_mono, ch_left      selected channel response
//   out_left, out_right, out_valid    mixed output samples and update strobe
//   busy                              frame in progress
//   overrun, overrun_clr              sticky dropped-tick flag and its clear
module apu_mixer #(
    parameter int CHANNELS = 8,
    parameter int SAMPLE_W = 16,
    parameter int VOL_W    = 8,
    localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_tick,
    output logic                ch_req,
    output logic [SEL_W-1:0]    ch_sel,
    input  logic                ch_valid,
    input  logic [SAMPLE_W-1:0] ch_sample,
    input  logic [VOL_W-1:0]    ch_volume,
    input  logic                ch_playing,
    input  logic                ch_mono,
    input  logic                ch_left,
    output logic [SAMPLE_W-1:0] out_left,
    output logic [SAMPLE_W-1:0] out_right,
    output logic                out_valid,
    output logic                busy,
    output logic                overrun,
    input  logic                overrun_clr
);

    // Product width, plus headroom for summing CHANNELS products without overflow.
    localparam int P_W   = SAMPLE_W + VOL_W + 1;
    localparam int ACC_W = P_W + ((CHANNELS > 1) ? $clog2(CHANNELS) : 0);

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W - SAMPLE_W + 1){1'b0}}, {(SAMPLE_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, REQ, MAC, OUT} state_t;

    state_t                    state;
    logic [SAMPLE_W-1:0]       sample_r;
    logic [VOL_W-1:0]          volume_r;
    logic                      playing_r;
    logic                      mono_r;
    logic                      left_r;
    logic signed [ACC_W-1:0]   acc_l;
    logic signed [ACC_W-1:0]   acc_r;
    logic signed [ACC_W-1:0]   prod;
    logic [SAMPLE_W-1:0]       sat_l;
    logic [SAMPLE_W-1:0]       sat_r;

    // Floor-divide by 2^VOL_W, then clamp to the signed output range.
    function automatic logic [SAMPLE_W-1:0] scale_sat(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s;
        s = a >>> VOL_W;
        if (s > SAT_MAX)
            return SAT_MAX[SAMPLE_W-1:0];
        else if (s < SAT_MIN)
            return SAT_MIN[SAMPLE_W-1:0];
        else
            return s[SAMPLE_W-1:0];
    endfunction

    // Signed sample times zero-extended volume; exact because P_W <= ACC_W.
    always_comb begin
        prod = $signed({{(ACC_W - SAMPLE_W){sample_r[SAMPLE_W-1]}}, sample_r})
             * $signed({{(ACC_W - VOL_W){1'b0}}, volume_r});
        if (!playing_r)
            prod = '0;
        sat_l = scale_sat(acc_l);
        sat_r = scale_sat(acc_r);
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ch_req    <= 1'b0;
            ch_sel    <= '0;
            sample_r  <= '0;
            volume_r  <= '0;
            playing_r <= 1'b0;
            mono_r    <= 1'b0;
            left_r    <= 1'b0;
            acc_l     <= '0;
            acc_r     <= '0;
            out_left  <= '0;
            out_right <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= 1'b0;

            // A tick during a frame is dropped; setting takes priority over clearing.
            if (sample_tick && state != IDLE)
                overrun <= 1'b1;
            else if (overrun_clr)
                overrun <= 1'b0;

            case (state)
                IDLE: begin
                    if (sample_tick) begin
                        acc_l  <= '0;
                        acc_r  <= '0;
                        ch_sel <= '0;
                        ch_req <= 1'b1;
                        state  <= REQ;
                    end
                end
                REQ: begin
                    if (ch_valid) begin
                        sample_r  <= ch_sample;
                        volume_r  <= ch_volume;
                        playing_r <= ch_playing;
                        mono_r    <= ch_mono;
                        left_r    <= ch_left;
                        ch_req    <= 1'b0;
                        state     <= MAC;
                    end
                end
                MAC: begin
                    if (mono_r || left_r)
                        acc_l <= acc_l + prod;
                    if (mono_r || !left_r)
                        acc_r <= acc_r + prod;
                    if (ch_sel == SEL_W'(CHANNELS - 1)) begin
                        state <= OUT;
                    end else begin
                        ch_sel <= ch_sel + SEL_W'(1);
                        ch_req <= 1'b1;
                        state  <= REQ;
                    end
                end
                OUT: begin
                    out_left  <= sat_l;
                    out_right <= sat_r;
                    out_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apu_mixer.sv
// tb/tb_apu_mixer.sv - directed-vector self-checking bench for apu_mixer
module tb_apu_mixer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sample_tick = 1'b0;
    logic        ch_req;
    logic [2:0]  ch_sel;
    logic        ch_valid;
    logic [15:0] ch_sample;
    logic [7:0]  ch_volume;
    logic        ch_playing;
    logic        ch_mono;
    logic        ch_left;
    logic [15:0] out_left;
    logic [15:0] out_right;
    logic        out_valid;
    logic        busy;
    logic        overrun;
    logic        overrun_clr = 1'b0;

    logic [15:0] smp [8];
    logic [7:0]  vol [8];
    logic        play [8];
    logic        mono [8];
    logic        lft [8];
    int          wait_cfg [8];
    int          wait_cnt = 0;

    int n_chk  = 0;
    int n_pass = 0;
    int lat;

    apu_mixer #(.CHANNELS(8), .SAMPLE_W(16), .VOL_W(8)) dut (
        .clk(clk), .rst(rst), .sample_tick(sample_tick),
        .ch_req(ch_req), .ch_sel(ch_sel), .ch_valid(ch_valid),
        .ch_sample(ch_sample), .ch_volume(ch_volume), .ch_playing(ch_playing),
        .ch_mono(ch_mono), .ch_left(ch_left),
        .out_left(out_left), .out_right(out_right), .out_valid(out_valid),
        .busy(busy), .overrun(overrun), .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    // Responder: valid held high while not requested (must be ignored), and
    // delayed by wait_cfg cycles while requested.
    assign ch_valid   = !ch_req || (wait_cnt >= wait_cfg[ch_sel]);
    assign ch_sample  = smp[ch_sel];
    assign ch_volume  = vol[ch_sel];
    assign ch_playing = play[ch_sel];
    assign ch_mono    = mono[ch_sel];
    assign ch_left    = lft[ch_sel];

    always @(posedge clk) begin
        if (ch_req && !ch_valid)
            wait_cnt <= wait_cnt + 1;
        else
            wait_cnt <= 0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_out(input string tag, input logic [15:0] el, input logic [15:0] er);
        check({tag, "_left"},  {16'b0, out_left},  {16'b0, el});
        check({tag, "_right"}, {16'b0, out_right}, {16'b0, er});
    endtask

    task automatic clear_cfg();
        for (int i = 0; i < 8; i++) begin
            smp[i] = 16'h1234; vol[i] = 8'h55; play[i] = 1'b0;
            mono[i] = 1'b1;    lft[i] = 1'b1;  wait_cfg[i] = 0;
        end
    endtask

    task automatic set_ch(input int i, input logic [15:0] s, input logic [7:0] v,
                          input logic m, input logic l);
        smp[i] = s; vol[i] = v; play[i] = 1'b1; mono[i] = m; lft[i] = l;
    endtask

    // Called at a negedge; returns at the negedge of the out_valid cycle with its cycle number.
    task automatic run_frame(input int xtick, input logic xclr, output int c);
        logic        pend;
        logic [2:0]  psel;
        logic [15:0] hl, hr;
        hl = out_left; hr = out_right;
        pend = 1'b0; psel = '0;
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        c = 1;
        check("busy_c1", {31'b0, busy}, 32'd1);
        check("req_c1", {31'b0, ch_req}, 32'd1);
        while (!out_valid && c < 200) begin
            if (pend) begin
                check("wait_req", {31'b0, ch_req}, 32'd1);
                check("wait_sel", {29'b0, ch_sel}, {29'b0, psel});
            end
            pend = ch_req && !ch_valid;
            psel = ch_sel;
            check("hold_out", {out_left, out_right}, {hl, hr});
            sample_tick = (c == xtick);
            overrun_clr = (c == xtick) && xclr;
            @(negedge clk);
            c++;
            if (xtick > 0 && c == xtick + 1)
                check("overrun_set", {31'b0, overrun}, 32'd1);
        end
        sample_tick = 1'b0;
        overrun_clr = 1'b0;
        check("out_valid_seen", {31'b0, out_valid}, 32'd1);
        check("busy_ov", {31'b0, busy}, 32'd0);
    endtask

    task automatic idle_check();
        @(negedge clk);
        check("ov_pulse", {31'b0, out_valid}, 32'd0);
        check("busy_idle", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c, nv;
        clear_cfg();
        repeat (3) @(negedge clk);
        check("rst_left", {16'b0, out_left}, 32'd0);
        check("rst_right", {16'b0, out_right}, 32'd0);
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_overrun", {31'b0, overrun}, 32'd0);
        check("rst_req", {31'b0, ch_req}, 32'd0);
        check("rst_sel", {29'b0, ch_sel}, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single channel: 0x4000 * 0x80 / 256 = 0x2000
        set_ch(0, 16'h4000, 8'h80, 1'b1, 1'b1);
        run_frame(0, 1'b0, lat);
        check("lat_single", lat, 32'd18);
        check_out("single", 16'h2000, 16'h2000);

        // Tick in the out_valid cycle is accepted (back-to-back frame)
        run_frame(0, 1'b0, lat);
        check("lat_b2b", lat, 32'd18);
        check_out("b2b", 16'h2000, 16'h2000);
        check("b2b_no_overrun", {31'b0, overrun}, 32'd0);
        idle_check();

        // Panning
        clear_cfg();
        set_ch(1, -16'sd1000, 8'd255, 1'b0, 1'b1);
        set_ch(2, 16'sd1000, 8'd255, 1'b0, 1'b0);
        run_frame(0, 1'b0, lat);
        check_out("pan", -16'sd997, 16'sd996);
        idle_check();

        // Saturation both directions
        clear_cfg();
        for (int i = 0; i < 8; i++) set_ch(i, 16'h7FFF, 8'd255, 1'b1, 1'b0);
        run_frame(0, 1'b0, lat);
        check_out("sat_pos", 16'h7FFF, 16'h7FFF);
        idle_check();
        for (int i = 0; i < 8; i++) smp[i] = 16'h8000;
        run_frame(0, 1'b0, lat);
        check_out("sat_neg", 16'h8000, 16'h8000);
        idle_check();

        // Wait states: left -255000+32768 -> -869, right 255000+32768 -> 1124
        clear_cfg();
        set_ch(1, -16'sd1000, 8'd255, 1'b0, 1'b1);
        set_ch(2, 16'sd1000, 8'd255, 1'b0, 1'b0);
        set_ch(4, 16'sd512, 8'd64, 1'b1, 1'b0);
        run_frame(0, 1'b0, lat);
        check("lat_nowait", lat, 32'd18);
        check_out("nowait", -16'sd869, 16'sd1124);
        idle_check();
        wait_cfg[4] = 3;
        run_frame(0, 1'b0, lat);
        check("lat_wait", lat, 32'd21);
        check_out("wait", -16'sd869, 16'sd1124);
        idle_check();

        // Overrun
        clear_cfg();
        set_ch(0, 16'h4000, 8'h80, 1'b1, 1'b1);
        run_frame(5, 1'b0, lat);
        check("lat_overrun", lat, 32'd18);
        check_out("overrun", 16'h2000, 16'h2000);
        idle_check();
        run_frame(5, 1'b1, lat);
        check("overrun_held", {31'b0, overrun}, 32'd1);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        check("overrun_clr", {31'b0, overrun}, 32'd0);

        // Reset mid-frame at cycle 9, with overrun set at cycle 5
        sample_tick = 1'b1;
        @(negedge clk);
        c = 1;
        while (c < 9) begin
            sample_tick = (c == 5);
            @(negedge clk);
            c++;
        end
        sample_tick = 1'b0;
        check("pre_rst_overrun", {31'b0, overrun}, 32'd1);
        rst = 1'b0;
        #1;
        check_out("midrst", 16'h0000, 16'h0000);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_req", {31'b0, ch_req}, 32'd0);
        check("midrst_sel", {29'b0, ch_sel}, 32'd0);
        check("midrst_overrun", {31'b0, overrun}, 32'd0);
        check("midrst_valid", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        nv = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) nv++;
        end
        check("no_partial_frame", nv, 32'd0);
        clear_cfg();
        set_ch(1, -16'sd1000, 8'd255, 1'b0, 1'b1);
        set_ch(2, 16'sd1000, 8'd255, 1'b0, 1'b0);
        run_frame(0, 1'b0, lat);
        check("lat_after_rst", lat, 32'd18);
        check_out("after_rst", -16'sd997, 16'sd996);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
